// File: rtl/io_pkg.sv
// io_pkg: shared types and default timing for the IO cycle controller.
//   io_region_e  - address region selected by a[13:10]
//   io_state_e   - bus-cycle FSM state (also exported for debug)
//   T_*_DEF      - default timing parameters, in clock cycles
//   is_external  - region drives a chip select and strobes
//   is_slow      - region uses the long strobe width
package io_pkg;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_ECONET,
        REG_ETH,
        REG_IDE,
        REG_IRQ,
        REG_PAGE,
        REG_UART,
        REG_NONE
    } io_region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } io_state_e;

    localparam int T_SETUP_DEF = 1;
    localparam int T_FAST_DEF  = 2;
    localparam int T_SLOW_DEF  = 4;
    localparam int T_HOLD_DEF  = 1;

    function automatic logic is_external(input io_region_e r);
        return (r == REG_ROM) || (r == REG_ECONET) || (r == REG_ETH) ||
               (r == REG_IDE) || (r == REG_UART);
    endfunction

    function automatic logic is_slow(input io_region_e r);
        return (r == REG_ECONET) || (r == REG_IDE) || (r == REG_UART);
    endfunction

endpackage

// File: rtl/io_region_decode.sv
// io_region_decode: purely combinational decode of host address a[13:10].
//   a_hi   in  4  host address bits [13:10]
//   region out    decoded io_region_e
module io_region_decode
    import io_pkg::*;
(
    input  logic [3:0] a_hi,
    output io_region_e region
);

    always_comb begin
        region = REG_NONE;
        if (!a_hi[3]) begin
            region = REG_ROM;
        end else begin
            case (a_hi[2:0])
                3'b000:  region = REG_ECONET;
                3'b001:  region = REG_ETH;
                3'b010:  region = REG_IDE;
                3'b011:  region = REG_IRQ;
                3'b100:  region = REG_PAGE;
                3'b101:  region = REG_UART;
                default: region = REG_NONE;
            endcase
        end
    end

endmodule

// File: rtl/io_cycle_ctrl.sv
// io_cycle_ctrl: sequences one host access at a time onto a shared device bus
// with programmable setup / strobe / hold timing, and serves the internal
// interrupt-status and page-latch registers without touching the bus.
//   clk, rst_n                   clock, async active-low reset
//   a[11:0] (= addr[13:2])       host address, sampled on host_req
//   host_req/host_wr/host_wdata  access request (one-cycle pulse)
//   host_rdata/host_ready/host_busy  completion and status to host
//   *_cs_n, dev_rd_n, dev_wr_n   device selects and shared strobes
//   dev_wdata/dev_rdata          device data
//   eth_cmd                      a[9] latched for Ethernet accesses
//   irq_in                       {uart, ide, eth, econet} interrupt levels
//   page                         flash page latch
//   fsm_state                    current FSM state (debug)
//
// Handshake: host_req is accepted only in IDLE; a request in any other state
// (including DONE) is dropped. Every accepted request produces exactly one
// host_ready pulse, during which host_rdata is valid for reads.
module io_cycle_ctrl
    import io_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_FAST  = T_FAST_DEF,
    parameter int T_SLOW  = T_SLOW_DEF,
    parameter int T_HOLD  = T_HOLD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] a,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        host_ready,
    output logic        host_busy,
    output logic        rom_cs_n,
    output logic        econet_cs_n,
    output logic        eth_cs_n,
    output logic        ide_cs_n,
    output logic        uart_cs_n,
    output logic        eth_cmd,
    output logic        dev_rd_n,
    output logic        dev_wr_n,
    output logic [7:0]  dev_wdata,
    input  logic [7:0]  dev_rdata,
    input  logic [3:0]  irq_in,
    output logic [5:0]  page,
    output io_state_e   fsm_state
);

    // Counter holds "cycles remaining minus one" for the current state.
    localparam logic [2:0] SETUP_LD = 3'(T_SETUP - 1);
    localparam logic [2:0] FAST_LD  = 3'(T_FAST - 1);
    localparam logic [2:0] SLOW_LD  = 3'(T_SLOW - 1);
    localparam logic [2:0] HOLD_LD  = 3'(T_HOLD - 1);

    io_state_e  state, state_next;
    io_region_e req_region, region_q;
    logic [2:0] cnt, cnt_load;
    logic       wr_q;
    logic       accept;
    logic       active;
    logic       unused_a;

    assign unused_a = ^a[6:0];

    io_region_decode u_decode (
        .a_hi   (a[11:8]),
        .region (req_region)
    );

    assign accept    = host_req && (state == ST_IDLE);
    assign fsm_state = state;

    // State register and cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= cnt_load;
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (host_req) state_next = is_external(req_region) ? ST_SETUP : ST_DONE;
            ST_SETUP:  if (cnt == 3'd0) state_next = ST_STROBE;
            ST_STROBE: if (cnt == 3'd0) state_next = ST_HOLD;
            ST_HOLD:   if (cnt == 3'd0) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Duration of the state being entered; region_q is already valid by
    // the time STROBE is entered.
    always_comb begin
        cnt_load = 3'd0;
        case (state_next)
            ST_SETUP:  cnt_load = SETUP_LD;
            ST_STROBE: cnt_load = is_slow(region_q) ? SLOW_LD : FAST_LD;
            ST_HOLD:   cnt_load = HOLD_LD;
            default:   cnt_load = 3'd0;
        endcase
    end

    // Access context and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_q   <= REG_NONE;
            wr_q       <= 1'b0;
            dev_wdata  <= '0;
            host_rdata <= '0;
            eth_cmd    <= 1'b0;
            page       <= '0;
        end else if (accept) begin
            region_q  <= req_region;
            wr_q      <= host_wr;
            dev_wdata <= host_wdata;
            eth_cmd   <= (req_region == REG_ETH) && a[7];   // a[7] is address bit 9
            case (req_region)
                REG_IRQ:  if (!host_wr) host_rdata <= {4'b0, irq_in};
                REG_PAGE: if (host_wr) page <= host_wdata[5:0];
                          else         host_rdata <= {2'b0, page};
                REG_NONE: if (!host_wr) host_rdata <= 8'hFF;
                default:  ;
            endcase
        end else if (state == ST_STROBE && cnt == 3'd0 && !wr_q) begin
            host_rdata <= dev_rdata;
        end else if (state == ST_DONE) begin
            eth_cmd <= 1'b0;
        end
    end

    // Outputs decoded from state: only one region is held per access, so
    // at most one select and one strobe can be active.
    always_comb begin
        active      = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
        rom_cs_n    = !(active && region_q == REG_ROM);
        econet_cs_n = !(active && region_q == REG_ECONET);
        eth_cs_n    = !(active && region_q == REG_ETH);
        ide_cs_n    = !(active && region_q == REG_IDE);
        uart_cs_n   = !(active && region_q == REG_UART);
        dev_rd_n    = !(state == ST_STROBE && !wr_q);
        dev_wr_n    = !(state == ST_STROBE && wr_q);
        host_ready  = (state == ST_DONE);
        host_busy   = (state != ST_IDLE);
    end

endmodule

// File: doc/io_cycle_ctrl.md
IO_CYCLE_CTRL -- requirements
Module: io_cycle_ctrl

Interface
REQ-001 Parameter T_SETUP, default 1, address/CS-to-strobe cycles (1..7).
REQ-002 Parameter T_FAST, default 2, strobe width for ROM and Ethernet (1..7).
REQ-003 Parameter T_SLOW, default 4, strobe width for Econet, IDE and UART (1..7).
REQ-004 Parameter T_HOLD, default 1, strobe-to-CS-release cycles (1..7).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 a  in  12  host address bits [13:2]; sampled on host_req.
REQ-008 host_req  in  1  one-cycle pulse starting an access.
REQ-009 host_wr  in  1  1 = write, 0 = read; sampled on host_req.
REQ-010 host_wdata  in  8  write data; sampled on host_req.
REQ-011 host_rdata  out  8  read data; valid while host_ready=1.
REQ-012 host_ready  out  1  one-cycle completion pulse.
REQ-013 host_busy  out  1  high from the cycle after host_req until host_ready, inclusive.
REQ-014 rom_cs_n, econet_cs_n, eth_cs_n, ide_cs_n, uart_cs_n  out  1 each  device selects, active-low.
REQ-015 eth_cmd  out  1  registered copy of a[9] for Ethernet accesses, 0 otherwise.
REQ-016 dev_rd_n, dev_wr_n  out  1  shared strobes, active-low.
REQ-017 dev_wdata  out  8  write data driven to devices.
REQ-018 dev_rdata  in  8  read data from devices.
REQ-019 irq_in  in  4  level interrupt sources {uart, ide, eth, econet}.
REQ-020 page  out  6  flash page latch.

Function
REQ-021 Region decode on a[13:10]: 0xxx ROM; 1000 Econet; 1001 Ethernet; 1010 IDE; 1011 interrupt status (internal); 1100 page latch (internal); 1101 UART; 1110/1111 unmapped.
REQ-022 FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
REQ-023 IDLE + host_req to external region -> SETUP; selected cs_n low from the next cycle.
REQ-024 SETUP lasts T_SETUP cycles -> STROBE; dev_rd_n (read) or dev_wr_n (write) low for T_FAST or T_SLOW cycles by region.
REQ-025 Read data registered from dev_rdata on the last STROBE cycle.
REQ-026 STROBE -> HOLD: strobe high, cs_n still low for T_HOLD cycles -> DONE.
REQ-027 DONE lasts one cycle: host_ready=1, cs_n high -> IDLE.
REQ-028 Internal/unmapped region: IDLE + host_req -> DONE directly; host_ready one cycle after host_req; no cs_n or strobe activity.
REQ-029 Interrupt status read: host_rdata = {4'b0, irq_in} sampled in the host_req cycle; writes ignored.
REQ-030 Page latch write: page <= host_wdata[5:0]; read returns {2'b0, page}.
REQ-031 Unmapped read returns 8'hFF; unmapped write has no effect.
REQ-032 host_req while host_busy=1 or in the DONE cycle is ignored; no queueing.
REQ-033 dev_wdata holds the sampled write data from SETUP entry through DONE.
REQ-034 At most one cs_n low at any time; both strobes never low together.
REQ-035 Cycle counter is 3 bits, reloaded on each state entry; no wrap-around beyond 7.

Reset
REQ-036 rst_n low asynchronously forces: state IDLE, all cs_n=1, dev_rd_n=dev_wr_n=1, host_ready=0, host_busy=0, host_rdata=0, dev_wdata=0, eth_cmd=0, page=0.
REQ-037 Reset during an active access aborts it; no host_ready is issued for it.

Structure
REQ-038 Package io_pkg holds the region enumeration, FSM state type and default timing constants; io_cycle_ctrl imports io_pkg.
REQ-039 Region decode is a separate combinational sub-module, io_region_decode, instantiated once.

Verification
REQ-040 ROM read at a=12'h000, dev_rdata=8'h5A, defaults -> rom_cs_n low 4 cycles, dev_rd_n low 2 cycles, host_ready on cycle 5 after host_req, host_rdata=8'h5A.
REQ-041 IDE write at a[13:10]=1010, wdata=8'hC3 -> ide_cs_n low 6 cycles, dev_wr_n low 4 cycles, dev_wdata=8'hC3 throughout.
REQ-042 Page write 8'h2B then page read -> page=6'h2B, host_rdata=8'h2B, host_ready one cycle after each host_req, no cs_n activity.
REQ-043 irq_in=4'b1010, status read -> host_rdata=8'h0A; unmapped read at a[13:10]=1111 -> 8'hFF.
REQ-044 Second host_req during an Econet access -> ignored; exactly one host_ready is issued.
REQ-045 rst_n low mid-STROBE -> strobes and cs_n high immediately; no host_ready; next access completes normally.
